// File: rtl/pdm_pkg.sv
// Shared constants for the pulse-density modulator: integrator width offsets,
// dither LFSR seed/taps and the RZ frame-phase encodings.
package pdm_pkg;

  localparam int I1W_OFFSET      = 2;
  localparam int I2W_OFFSET      = 4;
  localparam int MIN_ENA_SPACING = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    FC_START    = 2'd0,
    FC_MARK     = 2'd1,
    FC_HOLD     = 2'd2,
    FC_HOLD_SAT = 2'(MIN_ENA_SPACING)
  } fc_phase_e;

  // The frame counter only needs to resolve the first two phases, so it parks at 3.
  function automatic fc_phase_e fc_advance(input fc_phase_e fc);
    case (fc)
      FC_START: return FC_MARK;
      FC_MARK:  return FC_HOLD;
      default:  return FC_HOLD_SAT;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying a 3-bit signed dither.
// Only built when PDM_MOD_DITHER_EN is defined.
`ifdef PDM_MOD_DITHER_EN
module lfsr16
  import pdm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic [2:0] dither
);

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (ena) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

  assign dither = state[2:0];

endmodule
`endif

// File: rtl/pdm_mod.sv
// Parametrised first/second-order PDM with NRZ or edge-balanced RZ framing.
// Optional input dither is enabled by defining PDM_MOD_DITHER_EN.
module pdm_mod
  import pdm_pkg::*;
#(
  parameter int DW  = 16,
  parameter int I1W = DW + I1W_OFFSET,
  parameter int I2W = DW + I2W_OFFSET
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic signed [DW-1:0] in,
  input  logic                 order2,
  input  logic                 rz,
  output logic                 pdm_p,
  output logic                 pdm_n,
  output logic                 clip
);

  localparam int S1W = I1W + 2;
  localparam int S2W = I2W + 2;

  localparam logic signed [S1W-1:0] HALF1  = {{(S1W-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [S2W-1:0] HALF2  = {{(S2W-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [I1W-1:0] I1_MAX = {1'b0, {(I1W-1){1'b1}}};
  localparam logic signed [I1W-1:0] I1_MIN = {1'b1, {(I1W-1){1'b0}}};
  localparam logic signed [I2W-1:0] I2_MAX = {1'b0, {(I2W-1){1'b1}}};
  localparam logic signed [I2W-1:0] I2_MIN = {1'b1, {(I2W-1){1'b0}}};

  logic                  q, q_nxt;
  logic [DW-1:0]         acc, acc_nxt;
  logic signed [I1W-1:0] i1, i1_nxt;
  logic signed [I2W-1:0] i2, i2_nxt;
  fc_phase_e             fc, fc_nxt;
  logic                  order_q, order_nxt;
  logic                  rz_q, rz_nxt;
  logic                  pdm_nxt;
  logic                  clip_nxt;

  logic signed [DW-1:0]  x;

`ifdef PDM_MOD_DITHER_EN
  localparam logic signed [DW-1:0] X_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] X_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [2:0]         dither;
  logic signed [DW:0] dsum;

  lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .dither (dither)
  );

  // Dither is a signed -4..+3 offset; the sum clamps back into the sample range.
  always_comb begin
    dsum = {in[DW-1], in} + {{(DW-2){dither[2]}}, dither};
    x    = in;
    if (dsum[DW] != dsum[DW-1]) begin
      x = dsum[DW] ? X_MIN : X_MAX;
    end else begin
      x = dsum[DW-1:0];
    end
  end
`else
  assign x = in;
`endif

  logic [DW-1:0]         ob;
  logic [DW:0]           fo_sum;
  logic signed [S1W-1:0] y1, s1;
  logic signed [S2W-1:0] y2, s2;
  logic signed [I1W-1:0] i1_new;
  logic signed [I2W-1:0] i2_new;
  logic                  sat1, sat2;

  // Candidate updates for both orders; the feedback level y follows the previous q.
  always_comb begin
    ob     = {~x[DW-1], x[DW-2:0]};
    fo_sum = {1'b0, acc} + {1'b0, ob};

    y1     = q ? HALF1 : -HALF1;
    s1     = {{2{i1[I1W-1]}}, i1} + {{(S1W-DW){x[DW-1]}}, x} - y1;
    sat1   = !((&s1[S1W-1:I1W-1]) || !(|s1[S1W-1:I1W-1]));
    i1_new = sat1 ? (s1[S1W-1] ? I1_MIN : I1_MAX) : s1[I1W-1:0];

    y2     = q ? HALF2 : -HALF2;
    s2     = {{2{i2[I2W-1]}}, i2} + {{(S2W-I1W){i1_new[I1W-1]}}, i1_new} - y2;
    sat2   = !((&s2[S2W-1:I2W-1]) || !(|s2[S2W-1:I2W-1]));
    i2_new = sat2 ? (s2[S2W-1] ? I2_MIN : I2_MAX) : s2[I2W-1:0];
  end

  // Next-state logic: framing runs every cycle, an ena cycle restarts the frame.
  always_comb begin
    q_nxt     = q;
    acc_nxt   = acc;
    i1_nxt    = i1;
    i2_nxt    = i2;
    order_nxt = order_q;
    rz_nxt    = rz_q;
    clip_nxt  = 1'b0;
    fc_nxt    = fc_advance(fc);
    pdm_nxt   = pdm_p;

    if (rz_q) begin
      case (fc)
        FC_START: pdm_nxt = 1'b1;
        FC_MARK:  pdm_nxt = q;
        default:  pdm_nxt = pdm_p;
      endcase
    end else if (fc == FC_START) begin
      pdm_nxt = q;
    end

    if (ena) begin
      order_nxt = order2;
      rz_nxt    = rz;
      fc_nxt    = FC_START;

      if (order2 != order_q) begin
        q_nxt   = 1'b0;
        acc_nxt = '0;
        i1_nxt  = '0;
        i2_nxt  = '0;
      end else if (order2) begin
        i1_nxt   = i1_new;
        i2_nxt   = i2_new;
        q_nxt    = ~i2_new[I2W-1];
        clip_nxt = sat1 | sat2;
      end else begin
        acc_nxt = fo_sum[DW-1:0];
        q_nxt   = fo_sum[DW];
      end

      // A new frame under RZ always opens low, truncating any unfinished pattern.
      if (rz) begin
        pdm_nxt = 1'b0;
      end else if (fc == FC_START) begin
        pdm_nxt = q;
      end else begin
        pdm_nxt = pdm_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= 1'b0;
      acc     <= '0;
      i1      <= '0;
      i2      <= '0;
      fc      <= FC_START;
      order_q <= 1'b0;
      rz_q    <= 1'b0;
      pdm_p   <= 1'b0;
      pdm_n   <= 1'b1;
      clip    <= 1'b0;
    end else begin
      q       <= q_nxt;
      acc     <= acc_nxt;
      i1      <= i1_nxt;
      i2      <= i2_nxt;
      fc      <= fc_nxt;
      order_q <= order_nxt;
      rz_q    <= rz_nxt;
      pdm_p   <= pdm_nxt;
      pdm_n   <= ~pdm_nxt;
      clip    <= clip_nxt;
    end
  end

endmodule
